// File: rtl/div_seq_if.sv
// -----------------------------------------------------------------------------
// div_seq_if
// Operand/result handshake bundle for the sequential divider.
//   in_valid  / in_ready  : operand handshake (requester -> divider)
//   in0, in1              : dividend, divisor (unsigned, WIDTH bits)
//   out_valid / out_ready : result handshake (divider -> consumer)
//   out                   : quotient
//   rem                   : remainder, present only when DIV_REM_OUT_EN is defined
// Modports: master = requester/consumer side, slave = divider side.
// -----------------------------------------------------------------------------
interface div_seq_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in0;
   logic [WIDTH-1:0] in1;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
`ifdef DIV_REM_OUT_EN
   logic [WIDTH-1:0] rem;
`endif

   modport master (
      output in_valid, in0, in1, out_ready,
`ifdef DIV_REM_OUT_EN
      input  rem,
`endif
      input  in_ready, out_valid, out
   );

   modport slave (
      input  in_valid, in0, in1, out_ready,
`ifdef DIV_REM_OUT_EN
      output rem,
`endif
      output in_ready, out_valid, out
   );
endinterface

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
// Iterative unsigned restoring divider: out = in0 / in1, one quotient bit per
// clock. Valid/ready handshakes on both the operand and the result side.
// Ports:
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : div_seq_if.slave (operand and result handshakes, see interface)
// Configuration macro:
//   DIV_REM_OUT_EN : when defined the remainder is driven on bus.rem; otherwise
//                    it is kept internally only. Quotient, timing and handshake
//                    are identical in both builds.
// Divide by zero returns an all-ones quotient and the dividend as remainder,
// one cycle after acceptance; all other operands take WIDTH cycles of CALC.
// -----------------------------------------------------------------------------
module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic     clock,
   input  logic     reset_n,
   div_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] quo_q;    // dividend shifting out at the top, quotient shifting in at the bottom
   logic [WIDTH-1:0] div_q;    // latched divisor
   logic [WIDTH-1:0] part_q;   // partial remainder
   logic [CW-1:0]    cnt_q;    // quotient bits still to produce
   logic [WIDTH-1:0] out_q;    // published quotient, held until the next result
`ifdef DIV_REM_OUT_EN
   logic [WIDTH-1:0] rem_q;    // published remainder
`endif

   logic             accept;
   logic             last_bit;
   logic [WIDTH:0]   r_shift;
   logic             fits;
   logic [WIDTH-1:0] r_next;
   logic [WIDTH-1:0] quo_next;

   // One restoring step. The compare runs at WIDTH+1 bits because the shifted
   // partial remainder can exceed the divisor range; the subtraction result is
   // always below the divisor, so WIDTH bits of difference are exact.
   always_comb begin
      r_shift  = {part_q, quo_q[WIDTH-1]};
      fits     = (r_shift >= {1'b0, div_q});
      r_next   = fits ? (r_shift[WIDTH-1:0] - div_q) : r_shift[WIDTH-1:0];
      quo_next = {quo_q[WIDTH-2:0], fits};
   end

   // NOTE: every output of a combinational block is given a default first, so
   // no path through the case leaves a signal unassigned and infers a latch.
   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               state_nxt = (bus.in1 == '0) ? DONE : CALC;
            end
         end
         CALC: begin
            if (cnt_q == CW'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept   = (state == IDLE) && bus.in_valid;
   assign last_bit = (state == CALC) && (cnt_q == CW'(1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         quo_q  <= '0;
         div_q  <= '0;
         part_q <= '0;
         cnt_q  <= '0;
         out_q  <= '0;
`ifdef DIV_REM_OUT_EN
         rem_q  <= '0;
`endif
      end else begin
         if (accept) begin
            quo_q  <= bus.in0;
            div_q  <= bus.in1;
            part_q <= '0;
            cnt_q  <= CW'(WIDTH);
            // Divide by zero skips CALC and publishes its fixed result at once.
            if (bus.in1 == '0) begin
               out_q <= '1;
`ifdef DIV_REM_OUT_EN
               rem_q <= bus.in0;
`endif
            end
         end else if (state == CALC) begin
            quo_q  <= quo_next;
            part_q <= r_next;
            cnt_q  <= cnt_q - CW'(1);
            // Results are published only on the final step so out/rem stay
            // at the previous result while the next division is running.
            if (last_bit) begin
               out_q <= quo_next;
`ifdef DIV_REM_OUT_EN
               rem_q <= r_next;
`endif
            end
         end
      end
   end

   assign bus.out = out_q;
`ifdef DIV_REM_OUT_EN
   assign bus.rem = rem_q;
`endif

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq
// Self-checking bench for div_seq at WIDTH=8. A vector table covers the
// arithmetic boundaries and latency; hand-written sequences cover output
// back-pressure and reset during CALC; a random phase with random out_ready
// runs against a golden / and % model. Expected results are queued when
// operands are accepted and compared when the result handshake occurs.
// Remainder checks are compiled in only when DIV_REM_OUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_div_seq;
   localparam int W      = 8;
   localparam int LAT    = W + 1;
   localparam int NRAND  = 1500;
   localparam int NV     = 12;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
   } res_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      int           lat;
   } vec_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   always #5 clock = ~clock;

   div_seq_if #(.WIDTH(W)) bus ();

   div_seq #(.WIDTH(W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   bit   sb_en    = 1'b0;
   bit   rnd_run  = 1'b0;
   res_t sb_q[$];
   vec_t vecs[NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic res_t golden(input logic [W-1:0] a, input logic [W-1:0] b);
      res_t g;
      if (b == '0) begin
         g.q = '1;
         g.r = a;
      end else begin
         g.q = a / b;
         g.r = a % b;
      end
      return g;
   endfunction

   function automatic logic [W-1:0] pick();
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
         0:       return '0;
         1:       return '1;
         2:       return W'(1);
         default: return W'($urandom_range(0, (1 << W) - 1));
      endcase
   endfunction

   // Scoreboard consumer: compare on the cycle the result handshake happens.
   always @(negedge clock) begin
      res_t e;
      if (reset_n && sb_en && bus.out_valid && bus.out_ready) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_result", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("sb_quotient", bus.out, e.q);
`ifdef DIV_REM_OUT_EN
            check("sb_remainder", bus.rem, e.r);
`endif
         end
      end
   end

   // Drive operands until accepted; the expected result is queued at acceptance.
   // Returns 1 ns after the accept edge. keep leaves in_valid asserted.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input res_t e,
                        input bit keep, output bit ok);
      ok           = 1'b0;
      bus.in_valid = 1'b1;
      bus.in0      = a;
      bus.in1      = b;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge clock);
         #1;
      end
      if (!ok) begin
         check("accept_timeout", 32'd0, 32'd1);
      end else begin
         sb_q.push_back(e);
         @(posedge clock);
         #1;
         if (!keep) bus.in_valid = 1'b0;
      end
   endtask

   // Count cycles from the accept edge until out_valid is seen (accept cycle = 1);
   // flags any cycle where in_ready was high while the divider was busy.
   task automatic wait_out(output int lat, output bit busy_bad);
      lat      = 1;
      busy_bad = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (bus.out_valid) break;
         if (bus.in_ready) busy_bad = 1'b1;
         @(posedge clock);
         #1;
         lat++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit   ok;
      bit   busy_bad;
      int   lat;
      int   n;
      res_t e;

      vecs[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,  LAT};
      vecs[1]  = '{8'd5,   8'd0,   8'hFF,  8'd5,  1};
      vecs[2]  = '{8'd255, 8'd1,   8'd255, 8'd0,  LAT};
      vecs[3]  = '{8'd3,   8'd200, 8'd0,   8'd3,  LAT};
      vecs[4]  = '{8'd0,   8'd3,   8'd0,   8'd0,  LAT};
      vecs[5]  = '{8'd255, 8'd255, 8'd1,   8'd0,  LAT};
      vecs[6]  = '{8'd200, 8'd13,  8'd15,  8'd5,  LAT};
      vecs[7]  = '{8'd128, 8'd2,   8'd64,  8'd0,  LAT};
      vecs[8]  = '{8'd1,   8'd255, 8'd0,   8'd1,  LAT};
      vecs[9]  = '{8'd0,   8'd0,   8'hFF,  8'd0,  1};
      vecs[10] = '{8'd77,  8'd9,   8'd8,   8'd5,  LAT};
      vecs[11] = '{8'd254, 8'd127, 8'd2,   8'd0,  LAT};

      bus.in_valid  = 1'b0;
      bus.in0       = '0;
      bus.in1       = '0;
      bus.out_ready = 1'b0;

      // Reset state
      #12;
      check("reset_in_ready", bus.in_ready, 32'd1);
      check("reset_out_valid", bus.out_valid, 32'd0);
      check("reset_out", bus.out, 32'd0);
`ifdef DIV_REM_OUT_EN
      check("reset_rem", bus.rem, 32'd0);
`endif
      #20;
      reset_n = 1'b1;
      sb_en   = 1'b1;
      @(posedge clock);
      #1;

      // Table: arithmetic boundaries and latency, out_ready always high
      bus.out_ready = 1'b1;
      for (int i = 0; i < NV; i++) begin
         e.q = vecs[i].q;
         e.r = vecs[i].r;
         issue(vecs[i].a, vecs[i].b, e, 1'b0, ok);
         wait_out(lat, busy_bad);
         check($sformatf("tbl%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("tbl%0d_busy_in_ready", i), {31'd0, busy_bad}, 32'd0);
         check($sformatf("tbl%0d_out", i), bus.out, vecs[i].q);
`ifdef DIV_REM_OUT_EN
         check($sformatf("tbl%0d_rem", i), bus.rem, vecs[i].r);
`endif
         @(posedge clock);
         #1;
         check($sformatf("tbl%0d_post_out_valid", i), bus.out_valid, 32'd0);
         check($sformatf("tbl%0d_post_in_ready", i), bus.in_ready, 32'd1);
      end

      // Back-pressure: result held, busy-time in_valid pulses ignored
      bus.out_ready = 1'b0;
      issue(8'd100, 8'd7, golden(8'd100, 8'd7), 1'b0, ok);
      wait_out(lat, busy_bad);
      check("bp_latency", lat, LAT);
      for (int i = 0; i < 5; i++) begin
         @(posedge clock);
         #1;
         bus.in_valid = (i % 2) == 0;
         bus.in0      = W'(i * 37 + 1);
         bus.in1      = W'(i + 1);
         @(negedge clock);
         check("bp_out_valid_held", bus.out_valid, 32'd1);
         check("bp_out_held", bus.out, 32'd14);
`ifdef DIV_REM_OUT_EN
         check("bp_rem_held", bus.rem, 32'd2);
`endif
         check("bp_in_ready_low", bus.in_ready, 32'd0);
      end
      @(posedge clock);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clock);
      #1;
      check("bp_post_out_valid", bus.out_valid, 32'd0);
      check("bp_post_in_ready", bus.in_ready, 32'd1);
      check("bp_out_retained", bus.out, 32'd14);
      issue(8'd20, 8'd4, golden(8'd20, 8'd4), 1'b0, ok);
      wait_out(lat, busy_bad);
      check("bp_next_latency", lat, LAT);
      check("bp_next_out", bus.out, 32'd5);
      @(posedge clock);
      #1;

      // Reset in the middle of CALC
      issue(8'd100, 8'd7, golden(8'd100, 8'd7), 1'b0, ok);
      repeat (3) @(posedge clock);
      #2;
      reset_n = 1'b0;
      sb_en   = 1'b0;
      #1;
      check("rst_in_ready", bus.in_ready, 32'd1);
      check("rst_out_valid", bus.out_valid, 32'd0);
      check("rst_out", bus.out, 32'd0);
`ifdef DIV_REM_OUT_EN
      check("rst_rem", bus.rem, 32'd0);
`endif
      sb_q.delete();
      @(negedge clock);
      reset_n = 1'b1;
      sb_en   = 1'b1;
      @(posedge clock);
      #1;
      issue(8'd20, 8'd4, golden(8'd20, 8'd4), 1'b0, ok);
      wait_out(lat, busy_bad);
      check("rst_fresh_latency", lat, LAT);
      check("rst_fresh_out", bus.out, 32'd5);
`ifdef DIV_REM_OUT_EN
      check("rst_fresh_rem", bus.rem, 32'd0);
`endif
      @(posedge clock);
      #1;

      // Random operands, random back-to-back issue, random out_ready
      rnd_run = 1'b1;
      fork
         begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            for (int i = 0; i < NRAND; i++) begin
               a = pick();
               b = pick();
               issue(a, b, golden(a, b), $urandom_range(0, 1) == 1, ok);
               if (!ok) break;
            end
            bus.in_valid = 1'b0;
            rnd_run      = 1'b0;
         end
         begin
            while (rnd_run) begin
               @(posedge clock);
               #1;
               bus.out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      bus.out_ready = 1'b1;
      n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         @(posedge clock);
         n++;
      end
      check("rand_drained", sb_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
